ea_resolver: RTL and testbench
==============================

Name: ea_resolver

Overview:
- Effective-address resolver for the 12-bit multicycle core, sitting between instruction decode and the 12-bit word memory.
- Decodes the memory-reference fields of the latched instruction and forms the direct address from page-zero or current-page addressing.
- For indirect instructions it reads the pointer word from memory and presents the final effective address (EA) to the datapath with a valid strobe.
- It drives the memory's read/write/address/write-data inputs and consumes its read data.

Parameters:
- WIDTH, 12, data and address word width.
- OFFSET_W, 7, instruction offset field width (bits 6:0).
- MEM_LAT, 1, cycles from mem_read assertion until mem_rdata is valid; must be at least 1.
- AUTO_LO, 8, lowest auto-index address (used only with the optional feature).
- AUTO_HI, 15, highest auto-index address (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request to resolve; sampled only in IDLE.
- instr  in  WIDTH  instruction word: [11:9] opcode, [8] indirect, [7] page, [6:0] offset.
- pc  in  WIDTH  address of the current instruction, used for current-page addressing.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data.
- ea  out  WIDTH  resolved effective address; held until the next accepted start.
- ea_valid  out  1  one-cycle strobe marking ea valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: asynchronous on rst_n low. FSM goes to IDLE; all outputs are driven to 0.
- States: IDLE, PTR_RD, PTR_WAIT, AUTO_WR, DONE.
- Accept (IDLE with start=1, cycle 0): latch instr and pc.
  - Direct address: dir = page ? {pc[11:7], offset} : {5'b0, offset}.
- Direct path: taken when indirect=0, or when opcode is 3'b110 or 3'b111 (indirect bit ignored for these).
  - Go to DONE with ea=dir. ea_valid=1 in cycle 1. No memory access.
- Indirect path:
  - PTR_RD (cycle 1): mem_addr=dir, mem_read=1.
  - PTR_WAIT: lasts MEM_LAT cycles. mem_read and mem_addr are held. mem_rdata is captured as ptr at the end of the last wait cycle.
  - DONE: ea=ptr, ea_valid=1. With MEM_LAT=1 this is cycle 3.
- DONE: lasts one cycle, then returns to IDLE. busy=0 from the following cycle.
- mem_write is 0 everywhere except AUTO_WR. mem_read is 1 only in PTR_RD and PTR_WAIT. mem_read and mem_write are never high together.
- start is ignored while busy; instr and pc may change freely while busy.
- Address arithmetic is unsigned WIDTH bits and wraps mod 4096.
- Reset asserted mid-operation: immediate return to IDLE. No write is issued; any pending write is dropped.

Optional Feature:
- Macro: EA_AUTOINDEX_EN.
- Defined:
  - Auto-index applies on the indirect path when AUTO_LO <= dir <= AUTO_HI.
  - After the PTR_WAIT capture, enter AUTO_WR for one cycle: mem_addr=dir, mem_wdata=ptr+1 (wraps 4095 -> 0), mem_write=1.
  - Then DONE with ea=ptr+1. Latency is one cycle longer (cycle 4 with MEM_LAT=1).
- Undefined:
  - The AUTO_WR state and its comparator are not compiled; auto-index addresses behave like any other indirect location.
  - mem_write and mem_wdata are tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode enum (AND=0, ADD=1, ISZ=2, DCA=3, JMS=4, JMP=5, IOT=6, OPR=7);
  - instruction field bit positions;
  - the WORD_W=12 constant;
  - the ea_state_t enum.
- One natural sub-module: ea_page_calc, combinational, (instr, pc) -> dir.

Test Plan:
- Direct: instr={3'd2,0,0,7'd43}, pc=5 -> ea=43 with ea_valid in cycle 1; mem_read never asserted.
- Current page: instr={3'd1,0,1,7'd5}, pc=300 -> ea=261 in cycle 1.
- Indirect: memory[40]=1000, instr={3'd1,1,0,7'd40} -> mem_read=1 with mem_addr=40 in cycles 1-2; ea=1000 with ea_valid in cycle 3.
- Auto-index (EA_AUTOINDEX_EN): memory[9]=4095, instr={3'd1,1,0,7'd9} -> write of 0 to address 9 in cycle 3; ea=0 in cycle 4. Without the macro: ea=4095 in cycle 3 and no write.
- OPR with indirect set: instr={3'd7,1,0,7'd0} -> direct path, ea=0 in cycle 1, no mem_read. A second start pulsed during an indirect resolve is ignored.
- Reset mid-operation: rst_n low during PTR_WAIT -> busy=0, mem_read=0, ea_valid=0 immediately. The next start resolves normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 12-bit multicycle core: word width, instruction
// field positions, opcodes and the effective-address resolver state set.
package cpu_pkg;

  localparam int WORD_W   = 12;
  localparam int OPC_HI   = 11;
  localparam int OPC_LO   = 9;
  localparam int IND_BIT  = 8;
  localparam int PAGE_BIT = 7;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_ISZ = 3'd2,
    OP_DCA = 3'd3,
    OP_JMS = 3'd4,
    OP_JMP = 3'd5,
    OP_IOT = 3'd6,
    OP_OPR = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR_RD,
    ST_PTR_WAIT,
    ST_AUTO_WR,
    ST_DONE
  } ea_state_t;

  // IOT and OPR reuse the indirect bit as part of their own encoding.
  function automatic logic opc_forces_direct(opcode_e op);
    return (op == OP_IOT) || (op == OP_OPR);
  endfunction

endpackage

// File: rtl/ea_page_calc.sv
// Direct-address former: page-zero or current-page address from the offset
// field and the page bits of the instruction's own address.
module ea_page_calc #(
  parameter int WIDTH    = 12,
  parameter int OFFSET_W = 7
) (
  input  logic                page,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [WIDTH-1:0]    pc,
  output logic [WIDTH-1:0]    dir
);

  localparam logic [WIDTH-1:0] PAGE_MASK = {{(WIDTH-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  logic [WIDTH-1:0] offset_ext;

  assign offset_ext = {{(WIDTH-OFFSET_W){1'b0}}, offset};
  assign dir        = page ? ((pc & PAGE_MASK) | offset_ext) : offset_ext;

endmodule

// File: rtl/ea_resolver.sv
// Effective-address resolver: direct, indirect and (with EA_AUTOINDEX_EN
// defined) auto-incrementing indirect addressing against the word memory.
//
// state       | meaning
// ST_IDLE     | waiting for start
// ST_PTR_RD   | first cycle of the pointer read
// ST_PTR_WAIT | holding the read for MEM_LAT cycles, capture on the last
// ST_AUTO_WR  | write back incremented pointer (EA_AUTOINDEX_EN only)
// ST_DONE     | ea valid for one cycle
module ea_resolver
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int OFFSET_W = 7,
  parameter int MEM_LAT  = 1,
  parameter int AUTO_LO  = 8,
  parameter int AUTO_HI  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] pc,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] ea,
  output logic             ea_valid,
  output logic             busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  if (WIDTH != WORD_W || MEM_LAT < 1 || AUTO_LO > AUTO_HI) begin : g_bad_cfg
    $error("ea_resolver: unsupported parameter combination");
  end

  ea_state_t        state, state_nxt;
  logic [WIDTH-1:0] dir, dir_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             go_indirect, wait_last, auto_hit;

  ea_page_calc #(.WIDTH(WIDTH), .OFFSET_W(OFFSET_W)) u_page_calc (
    .page   (instr[PAGE_BIT]),
    .offset (instr[OFFSET_W-1:0]),
    .pc     (pc),
    .dir    (dir)
  );

  assign go_indirect = instr[IND_BIT] && !opc_forces_direct(opcode_e'(instr[OPC_HI:OPC_LO]));
  assign wait_last   = (wait_cnt == '0);

`ifdef EA_AUTOINDEX_EN
  logic [WIDTH-1:0] ptr_q;

  assign auto_hit = (dir_q >= WIDTH'(AUTO_LO)) && (dir_q <= WIDTH'(AUTO_HI));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= '0;
    else if (state == ST_PTR_WAIT && wait_last)
      ptr_q <= mem_rdata;
  end
`else
  assign auto_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (start) state_nxt = go_indirect ? ST_PTR_RD : ST_DONE;
      ST_PTR_RD:   state_nxt = ST_PTR_WAIT;
      ST_PTR_WAIT: if (wait_last) state_nxt = auto_hit ? ST_AUTO_WR : ST_DONE;
      ST_AUTO_WR:  state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // wait_cnt is a down-counter; the pointer is captured at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q    <= '0;
      wait_cnt <= '0;
      ea       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          dir_q <= dir;
          if (!go_indirect) ea <= dir;
        end
        ST_PTR_RD: wait_cnt <= CNT_W'(MEM_LAT - 1);
        ST_PTR_WAIT: begin
          if (!wait_last)
            wait_cnt <= wait_cnt - 1'b1;
          else if (!auto_hit)
            ea <= mem_rdata;
        end
`ifdef EA_AUTOINDEX_EN
        ST_AUTO_WR: ea <= ptr_q + 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    ea_valid = (state == ST_DONE);
    mem_read = (state == ST_PTR_RD) || (state == ST_PTR_WAIT);
    mem_addr = '0;
    if (mem_read) mem_addr = dir_q;
`ifdef EA_AUTOINDEX_EN
    mem_write = (state == ST_AUTO_WR);
    mem_wdata = '0;
    if (mem_write) begin
      mem_addr  = dir_q;
      mem_wdata = ptr_q + 1'b1;
    end
`else
    mem_write = 1'b0;
    mem_wdata = '0;
`endif
  end

endmodule

// File: tb/tb_ea_resolver.sv
// Randomized bench for ea_resolver against a cycle-level reference model of
// the addressing rules; follows EA_AUTOINDEX_EN when it is defined.
module tb_ea_resolver;

  localparam int LAT = 1;
`ifdef EA_AUTOINDEX_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] instr = '0;
  logic [11:0] pc = '0;
  logic        mem_read, mem_write, ea_valid, busy;
  logic [11:0] mem_addr, mem_wdata, mem_rdata, ea;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] seed_mem [4096];
  logic [11:0] wmem     [4096];
  bit          wvalid   [4096];
  logic [11:0] ref_mem  [4096];

  ea_resolver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .pc        (pc),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ea        (ea),
    .ea_valid  (ea_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] cur_mem(input logic [11:0] a);
    return wvalid[a] ? wmem[a] : seed_mem[a];
  endfunction

  // One-cycle read latency memory.
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= cur_mem(mem_addr);
    if (mem_write) begin
      wmem[mem_addr]   <= mem_wdata;
      wvalid[mem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_op(input logic [11:0] ins, input logic [11:0] p);
    logic [11:0] dir, ptr, exp_ea;
    bit          ind, auto_i, exp_rd, exp_wr;
    int          lat;
    dir    = ins[7] ? 12'((int'(p) / 128) * 128 + int'(ins) % 128) : 12'(int'(ins) % 128);
    ind    = ins[8] && (ins[11:9] < 3'd6);
    auto_i = AUTO && ind && (dir >= 12'd8) && (dir <= 12'd15);
    ptr    = ref_mem[dir];
    exp_ea = !ind ? dir : (auto_i ? ptr + 12'd1 : ptr);
    lat    = !ind ? 1 : (2 + LAT + (auto_i ? 1 : 0));
    @(negedge clk);
    start = 1'b1;
    instr = ins;
    pc    = p;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      exp_rd = ind && (k <= 1 + LAT);
      exp_wr = auto_i && (k == 2 + LAT);
      chk("ctl", 32'({busy, ea_valid, mem_read, mem_write}),
          32'({k <= lat, k == lat, exp_rd, exp_wr}));
      if (exp_rd || exp_wr) chk("addr", 32'(mem_addr), 32'(dir));
      if (exp_wr) chk("wdata", 32'(mem_wdata), 32'(ptr + 12'd1));
      if (k >= lat) chk("ea", 32'(ea), 32'(exp_ea));
      if (k <= lat) begin
        start = (k == 1) ? 1'b1 : 1'($urandom % 2);
        instr = 12'($urandom);
        pc    = 12'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    if (auto_i) ref_mem[dir] = ptr + 12'd1;
    chk("mem", 32'(cur_mem(dir)), 32'(ref_mem[dir]));
  endtask

  initial begin
    logic [11:0] ins;
    for (int i = 0; i < 4096; i++) begin
      seed_mem[i] = 12'($urandom);
    end
    seed_mem[40] = 12'd1000;
    seed_mem[9]  = 12'd4095;
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed_mem[i];

    #12;
    chk("rst_ctl", 32'({busy, ea_valid, mem_read, mem_write}), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_ea", 32'(ea), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op({3'd2, 1'b0, 1'b0, 7'd43}, 12'd5);
    run_op({3'd1, 1'b0, 1'b1, 7'd5}, 12'd300);
    run_op({3'd1, 1'b1, 1'b0, 7'd40}, 12'd77);
    run_op({3'd1, 1'b1, 1'b0, 7'd9}, 12'd0);
    run_op({3'd7, 1'b1, 1'b0, 7'd0}, 12'd2000);
    run_op({3'd6, 1'b1, 1'b1, 7'd127}, 12'd4095);
    run_op({3'd0, 1'b1, 1'b1, 7'd3}, 12'd4000);

    // Reset during PTR_WAIT of an auto-index-range pointer fetch.
    @(negedge clk);
    start = 1'b1;
    instr = {3'd1, 1'b1, 1'b0, 7'd10};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_rd", 32'({busy, mem_read}), 32'(2'b11));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({busy, ea_valid, mem_read, mem_write}), 32'(0));
    chk("mid_rst_ea", 32'(ea), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_mem", 32'(cur_mem(12'd10)), 32'(ref_mem[10]));
    run_op({3'd3, 1'b1, 1'b0, 7'd10}, 12'd55);

    for (int n = 0; n < 80; n++) begin
      ins = 12'($urandom);
      if ($urandom % 3 == 0) ins = {ins[11:9], 1'b1, 1'b0, 7'(8 + $urandom % 8)};
      run_op(ins, 12'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
